// File: rtl/save_load_store_pkg.sv
// Shared types and helpers for the pad-pattern recorder/player.
package save_load_pkg;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      LOC1 = 2'd1,
      LOC2 = 2'd2,
      LOC3 = 2'd3
   } slot_e;

   typedef enum logic [1:0] {
      IDLE,
      RECORD,
      PLAY,
      DONE
   } state_e;

   typedef enum logic [1:0] {
      DET_NEED_IDLE,
      DET_ARMED,
      DET_ACTIVE
   } det_state_e;

   localparam logic [4:0]  IDLE_PATTERN = 5'b11111;
   localparam int unsigned CODE_W       = 3;

   // Lowest active-low pad wins; idle pattern encodes to 0.
   function automatic logic [CODE_W-1:0] pad_encode(input logic [4:0] pat);
      logic found;
      pad_encode = '0;
      found      = 1'b0;
      for (int unsigned i = 0; i < 5; i++) begin
         if (!pat[i] && !found) begin
            pad_encode = CODE_W'(i + 1);
            found      = 1'b1;
         end
      end
   endfunction

   function automatic slot_e decode_slot(input logic [31:0] sel);
      decode_slot = (sel < 32'd4) ? slot_e'(sel[1:0]) : NONE;
   endfunction

endpackage

// File: rtl/save_load_store_pad_hit_detector.sv
// Debounced pad hit detector: registers the raw pattern, requires a stable idle
// window, then a stable code window, and emits one single-cycle hit per press.
module pad_hit_detector
   import save_load_pkg::*;
#(
   parameter int unsigned DEBOUNCE = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [4:0]        pad_i,
   output logic              hit_o,
   output logic [CODE_W-1:0] code_o
);

   localparam int unsigned    CW   = $clog2(DEBOUNCE + 1);
   localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE - 1);

   logic [4:0]        pad_q;
   det_state_e        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic              hit_q, hit_d;
   logic              idle;
   logic [CODE_W-1:0] enc;

   assign idle = (pad_q == IDLE_PATTERN);
   assign enc  = pad_encode(pad_q);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      hit_d   = 1'b0;
      case (state_q)
         DET_NEED_IDLE: begin
            if (!idle) begin
               cnt_d = '0;
            end else if (cnt_q >= LAST) begin
               state_d = DET_ARMED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DET_ARMED: begin
            if (!idle) begin
               code_d  = enc;
               state_d = DET_ACTIVE;
               cnt_d   = CW'(1);
            end
         end
         DET_ACTIVE: begin
            // An early release counts as the first sample of a fresh idle window.
            if (idle) begin
               state_d = DET_NEED_IDLE;
               cnt_d   = CW'(1);
            end else if (enc != code_q) begin
               code_d = enc;
               cnt_d  = CW'(1);
            end else if (cnt_q >= LAST) begin
               hit_d   = 1'b1;
               state_d = DET_NEED_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = DET_NEED_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pad_q   <= IDLE_PATTERN;
         state_q <= DET_NEED_IDLE;
         cnt_q   <= '0;
         code_q  <= '0;
         hit_q   <= 1'b0;
      end else begin
         pad_q   <= pad_i;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         hit_q   <= hit_d;
      end
   end

   assign hit_o  = hit_q;
   assign code_o = code_q;

endmodule

// File: rtl/save_load_store.sv
// Records debounced pad hits into one of three slots and replays a slot as the
// expected pad code, scoring live hits against it.
module save_load_store
   import save_load_pkg::*;
#(
   parameter int unsigned DEPTH    = 64,
   parameter int unsigned DEBOUNCE = 4
) (
   input  logic        iVGA_CLK,
   input  logic        iRST,
   input  logic [31:0] save_signal,
   input  logic [31:0] sensor_input_to_save,
   input  logic [31:0] load_signal,
   input  logic [31:0] sensor_input,
   output logic [31:0] sensor_output_adjusted,
   output logic [7:0]  slot_len,
   output logic        rec_full,
   output logic        play_done,
   output logic [15:0] hit_count,
   output logic [15:0] miss_count
);

   localparam int unsigned   AW      = $clog2(DEPTH);
   localparam int unsigned   PW      = AW + 1;
   localparam logic [PW-1:0] DEPTH_V = PW'(DEPTH);

   slot_e             sv, ld;
   state_e            state_q, state_d;
   slot_e             slot_q, slot_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]     len_q [4];
   logic [PW-1:0]     cur_len;
   logic [15:0]       hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
   logic              done_q, done_d;
   logic [CODE_W-1:0] out_q, out_d;
   logic [CODE_W-1:0] rd_data_q;
   logic [CODE_W-1:0] mem [3*DEPTH];
   logic              rec_start, play_start, rec_wr, play_hit;
   logic              save_hit, live_hit;
   logic [CODE_W-1:0] save_code, live_code;
   logic [1:0]        wr_bank, rd_bank;
   logic [AW+1:0]     wr_addr, rd_addr;
   logic              unused_bits;

   assign sv          = decode_slot(save_signal);
   assign ld          = decode_slot(load_signal);
   assign cur_len     = len_q[slot_q];
   assign unused_bits = ^{sensor_input_to_save[31:5], sensor_input[31:5]};

   pad_hit_detector #(.DEBOUNCE(DEBOUNCE)) u_save_det (
      .clk_i  (iVGA_CLK),
      .rst_i  (iRST),
      .pad_i  (sensor_input_to_save[4:0]),
      .hit_o  (save_hit),
      .code_o (save_code)
   );

   pad_hit_detector #(.DEBOUNCE(DEBOUNCE)) u_live_det (
      .clk_i  (iVGA_CLK),
      .rst_i  (iRST),
      .pad_i  (sensor_input[4:0]),
      .hit_o  (live_hit),
      .code_o (live_code)
   );

   // Save always outranks load, including from PLAY/DONE.
   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      case (state_q)
         IDLE: begin
            if (sv != NONE) begin
               state_d = RECORD;
               slot_d  = sv;
            end else if (ld != NONE) begin
               state_d = PLAY;
               slot_d  = ld;
            end
         end
         RECORD: begin
            if (sv == NONE) begin
               state_d = IDLE;
               slot_d  = NONE;
            end else begin
               slot_d = sv;
            end
         end
         PLAY, DONE: begin
            if (sv != NONE) begin
               state_d = RECORD;
               slot_d  = sv;
            end else if (ld == NONE) begin
               state_d = IDLE;
               slot_d  = NONE;
            end else if (ld != slot_q) begin
               state_d = PLAY;
               slot_d  = ld;
            end else if (state_q == PLAY && rd_ptr_q == cur_len) begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
            slot_d  = NONE;
         end
      endcase
   end

   assign rec_start  = (state_d == RECORD) && (state_q != RECORD || slot_d != slot_q);
   assign play_start = (state_d == PLAY) &&
                       (!(state_q == PLAY || state_q == DONE) || slot_d != slot_q);
   assign rec_wr     = (state_q == RECORD) && (state_d == RECORD) && !rec_start &&
                       save_hit && (wr_ptr_q < DEPTH_V);
   assign play_hit   = (state_q == PLAY) && (state_d == PLAY) && !play_start &&
                       live_hit && (rd_ptr_q < cur_len);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      done_d     = done_q;
      out_d      = '0;
      if (rec_start) begin
         wr_ptr_d = '0;
      end else if (rec_wr) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (play_start) begin
         rd_ptr_d   = '0;
         hit_cnt_d  = '0;
         miss_cnt_d = '0;
         done_d     = 1'b0;
      end else begin
         if (play_hit) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (live_code == rd_data_q) begin
               if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
            end else begin
               if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
            end
         end
         if (state_d == DONE) done_d = 1'b1;
      end
      // rd_data_q tracks rd_ptr_q because the read address uses next-state values.
      if (state_q == PLAY && state_d == PLAY && !play_start && rd_ptr_q < cur_len) begin
         out_d = rd_data_q;
      end
   end

   assign wr_bank = slot_q - 2'd1;
   assign rd_bank = (slot_d == NONE) ? 2'd0 : slot_d - 2'd1;
   assign wr_addr = {wr_bank, wr_ptr_q[AW-1:0]};
   assign rd_addr = {rd_bank, rd_ptr_d[AW-1:0]};

   always_ff @(posedge iVGA_CLK) begin
      if (rec_wr && !iRST) mem[wr_addr] <= save_code;
      rd_data_q <= mem[rd_addr];
   end

   always_ff @(posedge iVGA_CLK) begin
      if (iRST) begin
         state_q    <= IDLE;
         slot_q     <= NONE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         done_q     <= 1'b0;
         out_q      <= '0;
         for (int unsigned i = 0; i < 4; i++) len_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         slot_q     <= slot_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
         done_q     <= done_d;
         out_q      <= out_d;
         if (rec_start) begin
            len_q[slot_d] <= '0;
         end else if (rec_wr) begin
            len_q[slot_q] <= len_q[slot_q] + 1'b1;
         end
      end
   end

   assign sensor_output_adjusted = {{(32 - CODE_W){1'b0}}, out_q};
   assign slot_len               = 8'(cur_len);
   assign rec_full               = (state_q == RECORD) && (wr_ptr_q == DEPTH_V);
   assign play_done              = done_q;
   assign hit_count              = hit_cnt_q;
   assign miss_count             = miss_cnt_q;

endmodule

// File: tb/tb_save_load_store.sv
// Scoreboard bench: stimulus queues expected playback codes and status checks,
// a negedge monitor compares them against the outputs.
module tb_save_load_store;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] save_sig, save_pad, load_sig, live_pad;
   logic [31:0] sensor_output_adjusted;
   logic [7:0]  slot_len;
   logic        rec_full, play_done;
   logic [15:0] hit_count, miss_count;

   always #5 clk = ~clk;

   save_load_store #(.DEPTH(64), .DEBOUNCE(4)) dut (
      .iVGA_CLK               (clk),
      .iRST                   (rst),
      .save_signal            (save_sig),
      .sensor_input_to_save   (save_pad),
      .load_signal            (load_sig),
      .sensor_input           (live_pad),
      .sensor_output_adjusted (sensor_output_adjusted),
      .slot_len               (slot_len),
      .rec_full               (rec_full),
      .play_done              (play_done),
      .hit_count              (hit_count),
      .miss_count             (miss_count)
   );

   typedef enum int {K_OUT, K_LEN, K_FULL, K_DONE, K_HIT, K_MISS, K_PEND} kind_e;
   typedef struct {
      string       name;
      kind_e       kind;
      int unsigned exp;
   } chk_t;

   chk_t        st_q[$];
   int unsigned exp_out_q[$];
   int          errors = 0;
   int          checks = 0;
   int unsigned prev_out = 0;

   function automatic int unsigned actual(input kind_e k);
      case (k)
         K_OUT:   actual = sensor_output_adjusted;
         K_LEN:   actual = {24'd0, slot_len};
         K_FULL:  actual = {31'd0, rec_full};
         K_DONE:  actual = {31'd0, play_done};
         K_HIT:   actual = {16'd0, hit_count};
         K_MISS:  actual = {16'd0, miss_count};
         K_PEND:  actual = exp_out_q.size();
         default: actual = 32'hDEAD_BEEF;
      endcase
   endfunction

   always @(negedge clk) begin
      chk_t        c;
      int unsigned got;
      int unsigned e;
      if (!rst && sensor_output_adjusted != prev_out) begin
         if (sensor_output_adjusted != 0) begin
            checks++;
            if (exp_out_q.size() == 0) begin
               errors++;
               $display("FAIL play_out: got %0d, required no output", sensor_output_adjusted);
            end else begin
               e = exp_out_q.pop_front();
               if (sensor_output_adjusted != e) begin
                  errors++;
                  $display("FAIL play_out: got %0d, required %0d", sensor_output_adjusted, e);
               end
            end
         end
         prev_out = sensor_output_adjusted;
      end
      while (st_q.size() > 0) begin
         c   = st_q.pop_front();
         got = actual(c.kind);
         checks++;
         if (got != c.exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", c.name, got, c.exp);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input kind_e k, input int unsigned exp);
      st_q.push_back('{name: name, kind: k, exp: exp});
   endtask

   task automatic flush();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [31:0] pad_pat(input int unsigned code);
      logic [31:0] p;
      p = 32'hFFFF_FFFF;
      if (code >= 1 && code <= 5) p[code-1] = 1'b0;
      return p;
   endfunction

   task automatic press_save(input int unsigned code, input int hold, input int rel);
      save_pad = pad_pat(code);
      tick(hold);
      save_pad = 32'hFFFF_FFFF;
      tick(rel);
   endtask

   task automatic press_live(input int unsigned code, input int hold, input int rel);
      live_pad = pad_pat(code);
      tick(hold);
      live_pad = 32'hFFFF_FFFF;
      tick(rel);
   endtask

   task automatic wait_done(input int max_cycles);
      for (int i = 0; i < max_cycles && play_done !== 1'b1; i++) tick(1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst      = 1'b1;
      save_sig = 0;
      load_sig = 0;
      save_pad = 32'hFFFF_FFFF;
      live_pad = 32'hFFFF_FFFF;
      tick(3);
      chk("rst_out", K_OUT, 0);
      chk("rst_len", K_LEN, 0);
      chk("rst_full", K_FULL, 0);
      chk("rst_done", K_DONE, 0);
      chk("rst_hit", K_HIT, 0);
      chk("rst_miss", K_MISS, 0);
      flush();
      rst = 1'b0;
      tick(2);

      // Record 1,3,5 into slot 1 and play it back with matching hits.
      save_sig = 1;
      tick(2);
      press_save(1, 6, 6);
      press_save(3, 6, 6);
      press_save(5, 6, 6);
      chk("rec_len", K_LEN, 3);
      chk("rec_notfull", K_FULL, 0);
      flush();
      save_sig = 0;
      tick(2);
      chk("idle_len", K_LEN, 0);
      flush();
      exp_out_q.push_back(1);
      exp_out_q.push_back(3);
      exp_out_q.push_back(5);
      load_sig = 1;
      tick(3);
      chk("play_len", K_LEN, 3);
      flush();
      press_live(1, 6, 6);
      press_live(3, 6, 6);
      press_live(5, 6, 6);
      wait_done(50);
      chk("play_done", K_DONE, 1);
      chk("play_hit", K_HIT, 3);
      chk("play_miss", K_MISS, 0);
      chk("play_end_out", K_OUT, 0);
      flush();
      load_sig = 0;
      tick(3);
      chk("hold_done", K_DONE, 1);
      chk("hold_hit", K_HIT, 3);
      flush();

      // Debounce boundary: 3 stable samples reject, 4 accept.
      save_sig = 2;
      tick(2);
      press_save(2, 3, 6);
      press_save(2, 3, 6);
      chk("bounce_len", K_LEN, 0);
      flush();
      press_save(2, 4, 6);
      chk("debounce_len", K_LEN, 1);
      flush();
      save_sig = 0;
      tick(2);

      // Fill slot 2 and overflow by one.
      save_sig = 2;
      tick(2);
      for (int unsigned i = 0; i < 64; i++) press_save((i % 5) + 1, 5, 5);
      chk("full_len", K_LEN, 64);
      chk("full_flag", K_FULL, 1);
      flush();
      press_save(1, 5, 5);
      chk("drop_len", K_LEN, 64);
      chk("drop_flag", K_FULL, 1);
      flush();
      save_sig = 0;
      tick(2);

      // Save wins over load; the held playback counters stay untouched.
      save_sig = 3;
      load_sig = 1;
      tick(4);
      chk("prio_out", K_OUT, 0);
      chk("prio_len", K_LEN, 0);
      chk("prio_hit_held", K_HIT, 3);
      flush();
      save_sig = 0;
      load_sig = 0;
      tick(2);

      // Empty slot 3 goes straight to DONE.
      load_sig = 3;
      tick(2);
      chk("empty_done", K_DONE, 1);
      chk("empty_out", K_OUT, 0);
      chk("empty_hit", K_HIT, 0);
      chk("empty_miss", K_MISS, 0);
      flush();
      load_sig = 0;
      tick(2);

      // Slot 3 holds {1,2}; play back with hits {1,4}.
      save_sig = 3;
      tick(2);
      press_save(1, 6, 6);
      press_save(2, 6, 6);
      save_sig = 0;
      tick(2);
      exp_out_q.push_back(1);
      exp_out_q.push_back(2);
      load_sig = 3;
      tick(3);
      press_live(1, 6, 6);
      press_live(4, 6, 6);
      wait_done(50);
      chk("mm_done", K_DONE, 1);
      chk("mm_hit", K_HIT, 1);
      chk("mm_miss", K_MISS, 1);
      chk("mm_out", K_OUT, 0);
      flush();
      load_sig = 0;
      tick(2);

      // Reset in the middle of playing slot 1.
      exp_out_q.push_back(1);
      load_sig = 1;
      tick(3);
      exp_out_q.push_back(3);
      press_live(1, 6, 6);
      rst = 1'b1;
      tick(1);
      chk("mrst_out", K_OUT, 0);
      chk("mrst_len", K_LEN, 0);
      chk("mrst_full", K_FULL, 0);
      chk("mrst_done", K_DONE, 0);
      chk("mrst_hit", K_HIT, 0);
      chk("mrst_miss", K_MISS, 0);
      flush();
      rst = 1'b0;
      tick(3);
      chk("mrst_len1", K_LEN, 0);
      chk("mrst_out1", K_OUT, 0);
      flush();
      load_sig = 2;
      tick(3);
      chk("mrst_len2", K_LEN, 0);
      flush();
      load_sig = 3;
      tick(3);
      chk("mrst_len3", K_LEN, 0);
      flush();
      load_sig = 0;
      tick(2);

      chk("pending_outputs", K_PEND, 0);
      flush();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/save_load_store.md
# save_load_store

Pad-pattern recorder/player that terminates the save/load request interface driven by the VGA menu controller. While a save slot is selected it debounces live pad hits, encodes them, and appends them to that slot. While a load slot is selected it replays the stored sequence as `sensor_output_adjusted`, advancing on each live hit and scoring it. It sits between the sensor front end and the VGA controller on the VGA pixel clock.

## Interface
- `DEPTH`, 64: entries per slot (power of two).
- `DEBOUNCE`, 4: consecutive stable cycles required to accept an active or idle pad pattern.
- `iVGA_CLK`  in  1  sole clock.
- `iRST`  in  1  reset; synchronous, active-high.
- `save_signal`  in  32  0 = none, 1..3 = record into slot 1..3.
- `sensor_input_to_save`  in  32  pad pattern used for recording; bits[4:0] active-low.
- `load_signal`  in  32  0 = none, 1..3 = play slot 1..3.
- `sensor_input`  in  32  live pad pattern used during playback; bits[4:0] active-low.
- `sensor_output_adjusted`  out  32  expected pad code (1..5) in bits[2:0], 0 when none; upper bits 0.
- `slot_len`  out  8  length of the slot currently selected for save or load.
- `rec_full`  out  1  current record slot holds DEPTH entries.
- `play_done`  out  1  playback has consumed every entry.
- `hit_count`  out  16  matching hits in the current playback.
- `miss_count`  out  16  mismatching hits in the current playback.

## Operation
- Pad encode: a pattern is idle when bits[4:0] = 5'b11111. Otherwise code = index of the lowest zero bit + 1, giving 1..5.
- Hit detect, one instance per input: idle must be held ≥ DEBOUNCE cycles, then the same non-idle code must be held DEBOUNCE cycles. This produces one single-cycle `hit` pulse with `code`. No further hit is produced until idle is held DEBOUNCE cycles again. A code change during the active window restarts the count.
- States:
  - IDLE → RECORD when save_signal ∈ 1..3.
  - IDLE → PLAY when load_signal ∈ 1..3.
  - RECORD/PLAY → IDLE when the selecting signal returns to 0.
  - PLAY → DONE when rd_ptr = len.
  - DONE → IDLE when load_signal = 0.
- Both selects nonzero: save wins. Load is ignored until save returns to 0.
- Values outside 0..3 are treated as 0.
- RECORD entry, or save_signal changing to a different slot:
  - wr_ptr ← 0 and len[slot] ← 0.
  - The previously selected slot keeps its length.
- RECORD hit with wr_ptr < DEPTH: mem[slot][wr_ptr] ← code, wr_ptr++, len[slot]++. Hit at DEPTH: dropped, rec_full = 1.
- PLAY entry, or load_signal changing slot: rd_ptr ← 0, hit_count ← 0, miss_count ← 0, play_done ← 0.
- PLAY hit:
  - code = expected → hit_count++; otherwise miss_count++.
  - Then rd_ptr++.
  - Counters saturate at 16'hFFFF.
- Empty slot (len = 0): PLAY goes straight to DONE and the output stays 0.
- Leaving PLAY/DONE holds hit_count, miss_count and play_done until the next PLAY entry.
- sensor_output_adjusted = 0 in IDLE, RECORD and DONE.

## Timing
- Reset: every output 0, all len = 0, pointers 0, state IDLE, detectors start in need-idle. Memory contents are not cleared.
- Hit latency: the pulse asserts on the edge after the DEBOUNCE-th stable active sample. The input register adds one further cycle.
- Write: memory and len update on the hit edge. slot_len reflects the new value the next cycle.
- Read: synchronous memory. sensor_output_adjusted is valid 1 cycle after rd_ptr changes or PLAY is entered.
- Score: counters update on the hit edge. A hit and a slot change in the same cycle: the slot change wins and the hit is discarded.
- Reset asserted mid-record or mid-play: the reset takes effect that edge and no partial write occurs.
- DONE: play_done asserts the cycle after the last scoring hit.

## Structure
- Package `save_load_pkg`:
  - Slot codes NONE/LOC1/LOC2/LOC3 = 0..3.
  - IDLE_PATTERN = 5'b11111.
  - State enum {IDLE, RECORD, PLAY, DONE}.
  - Pad code width = 3.
- Sub-module `pad_hit_detector` (debounce FSM, edge detect, priority encode), instantiated for `sensor_input_to_save` and `sensor_input`.
- Memory: 3×DEPTH×3-bit array, one write port and one synchronous read port.

## Test plan
- Record: save=1, hits on pads 1,3,5, save=0 → slot_len read back 3. Then load=1 → output 1, then 3, then 5. Hitting 1,3,5 gives hit_count = 3, miss_count = 0, play_done = 1, output 0.
- Bounce: a pad 2 press held 3 cycles (DEBOUNCE = 4), released and re-pressed → no hit recorded. Holding it 4 cycles → exactly one entry.
- Full: save=2 with 65 hits → slot_len = 64, rec_full = 1, the 65th hit dropped.
- Mismatch: slot holds {1,2}, playback hits {1,4} → hit_count = 1, miss_count = 1, play_done = 1.
- Priority and empty slot: save=3 and load=1 simultaneously → RECORD only, output 0. load=3 with len[3] = 0 → play_done = 1 on the next cycle, output 0.
- Reset mid-play: iRST during PLAY → all outputs 0 the next cycle and all lengths 0.
